product_accumulator: RTL and testbench

//  Downstream stage of the 4x4 array multiplier: consumes its 8-bit products p over a valid/ready

---
 rtl/product_accumulator_pkg.sv | 11 +
 rtl/product_accumulator_if.sv | 25 ++
 rtl/product_accumulator_acc_adder.sv | 19 +
 rtl/product_accumulator.sv | 62 ++++++
 tb/tb_product_accumulator.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: shared state encoding and default widths for the product accumulator
package mac_pkg;
  typedef enum logic {ACC, DONE} state_t;
  localparam int PROD_W_DEF = 8;
  localparam int COUNT_DEF = 4;
  localparam int ACC_W_DEF = 10;
  localparam int CNT_W = $clog2(COUNT_DEF) + 1;
  function automatic int cnt_w(input int count);
    return $clog2(count) + 1;
  endfunction
endpackage

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product input and burst result handshakes plus burst abort
interface product_accumulator_if #(
  parameter int PROD_W = mac_pkg::PROD_W_DEF,
  parameter int ACC_W = mac_pkg::ACC_W_DEF,
  parameter int CNT_W = mac_pkg::CNT_W
);
  logic clear;
  logic in_valid;
  logic in_ready;
  logic [PROD_W-1:0] in_prod;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic out_ovf;
  modport master (
    output clear, in_valid, in_prod, in_last, out_ready,
    input in_ready, out_valid, out_sum, out_cnt, out_ovf
  );
  modport slave (
    input clear, in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );
endinterface

// File: rtl/product_accumulator_acc_adder.sv
// acc_adder: zero-extending accumulator adder with carry; ACC_SATURATE_EN clamps on carry instead of wrapping
module acc_adder #(
  parameter int PROD_W = 8,
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);
  logic [ACC_W:0] raw;
  assign raw = {1'b0, a} + (ACC_W + 1)'(b);
  assign carry = raw[ACC_W];
`ifdef ACC_SATURATE_EN
  assign sum = carry ? '1 : raw[ACC_W-1:0];
`else
  assign sum = raw[ACC_W-1:0];
`endif
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums bursts of COUNT products into a registered result with sticky overflow (ACC_SATURATE_EN selects clamping)
module product_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int COUNT = COUNT_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input logic clk,
  input logic rst,
  product_accumulator_if.slave bus
);
  localparam int CW = cnt_w(COUNT);
  state_t state, state_nx;
  logic [ACC_W-1:0] acc, sum, out_sum;
  logic [CW-1:0] cnt, out_cnt;
  logic ovf, out_ovf, carry, accept, close;
  acc_adder #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
    .a(acc), .b(bus.in_prod), .sum(sum), .carry(carry)
  );
  // clear wins over a simultaneous accept
  assign accept = bus.in_valid & (state == ACC) & ~bus.clear;
  assign close = accept & (bus.in_last | (cnt == CW'(COUNT - 1)));
  always_comb begin
    state_nx = state;
    state_nx = (state == ACC) ? (close ? DONE : ACC) : (bus.out_ready ? ACC : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      out_sum <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ACC && bus.clear) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (close) begin
        out_sum <= sum;
        out_cnt <= cnt + 1'b1;
        out_ovf <= ovf | carry;
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (accept) begin
        acc <= sum;
        cnt <= cnt + 1'b1;
        ovf <= ovf | carry;
      end
    end
  end
  assign bus.in_ready = (state == ACC);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum = out_sum;
  assign bus.out_cnt = out_cnt;
  assign bus.out_ovf = out_ovf;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed and random scoreboard checks of product_accumulator, default and 9-bit overflow builds
module tb_product_accumulator;
  localparam int ACC_W = 10;
  localparam int COUNT = 4;
  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [2:0] cnt;
    logic ovf;
  } res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int ready_mode = 1;
  res_t q[$];
  logic [ACC_W-1:0] macc = '0;
  int mcnt = 0;
  logic movf = 1'b0;
  product_accumulator_if #(.PROD_W(8), .ACC_W(ACC_W), .CNT_W(3)) di ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(9), .CNT_W(3)) wi ();
  product_accumulator d (.clk(clk), .rst(rst), .bus(di));
  product_accumulator #(.ACC_W(9)) w (.clk(clk), .rst(rst), .bus(wi));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    macc = '0;
    mcnt = 0;
    movf = 1'b0;
  endtask

  task automatic send(input logic [7:0] p, input logic last);
    logic [ACC_W:0] t;
    int n;
    n = 0;
    di.in_valid = 1'b1;
    di.in_prod = p;
    di.in_last = last;
    while (!di.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 32'(n < 200), 1);
    if (n < 200) begin
      t = {1'b0, macc} + (ACC_W + 1)'(p);
      movf = movf | t[ACC_W];
`ifdef ACC_SATURATE_EN
      macc = t[ACC_W] ? {ACC_W{1'b1}} : t[ACC_W-1:0];
`else
      macc = t[ACC_W-1:0];
`endif
      mcnt++;
      if (last || mcnt == COUNT) begin
        q.push_back('{sum: macc, cnt: 3'(mcnt), ovf: movf});
        model_reset();
      end
      @(negedge clk);
    end
    di.in_valid = 1'b0;
    di.in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    di.out_ready = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    res_t e;
    if (!rst && di.out_valid && di.out_ready) begin
      chk("result_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_sum", 32'(di.out_sum), 32'(e.sum));
        chk("sb_cnt", 32'(di.out_cnt), 32'(e.cnt));
        chk("sb_ovf", 32'(di.out_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    logic [ACC_W-1:0] held;
    di.clear = 1'b0;
    di.in_valid = 1'b0;
    di.in_prod = '0;
    di.in_last = 1'b0;
    di.out_ready = 1'b1;
    wi.clear = 1'b0;
    wi.in_valid = 1'b0;
    wi.in_prod = '0;
    wi.in_last = 1'b0;
    wi.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(di.out_valid), 0);
    chk("rst_out_sum", 32'(di.out_sum), 0);
    chk("rst_out_cnt", 32'(di.out_cnt), 0);
    chk("rst_out_ovf", 32'(di.out_ovf), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(di.in_ready), 1);
    // async reset mid-burst
    send(8'd100, 1'b0);
    send(8'd200, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(di.out_valid), 0);
    chk("midrst_out_sum", 32'(di.out_sum), 0);
    chk("midrst_out_cnt", 32'(di.out_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    send(8'd4, 1'b0);
    drain();
    // full burst with latency check
    ready_mode = 0;
    @(negedge clk);
    send(8'd15, 1'b0);
    send(8'd225, 1'b0);
    send(8'd1, 1'b0);
    chk("full_not_early", 32'(di.out_valid), 0);
    send(8'd0, 1'b0);
    chk("full_valid", 32'(di.out_valid), 1);
    chk("full_sum", 32'(di.out_sum), 241);
    chk("full_cnt", 32'(di.out_cnt), 4);
    chk("full_ovf", 32'(di.out_ovf), 0);
    ready_mode = 1;
    drain();
    // backpressure: result held, in_ready low, extra product refused
    ready_mode = 0;
    @(negedge clk);
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b0);
    send(8'd40, 1'b0);
    held = di.out_sum;
    chk("bp_sum_first", 32'(held), 100);
    di.in_valid = 1'b1;
    di.in_prod = 8'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(di.out_valid), 1);
      chk("bp_in_ready", 32'(di.in_ready), 0);
      chk("bp_sum_stable", 32'(di.out_sum), 100);
      chk("bp_cnt_stable", 32'(di.out_cnt), 4);
    end
    di.in_valid = 1'b0;
    ready_mode = 1;
    drain();
    send(8'd5, 1'b1);
    drain();
    // early close
    ready_mode = 0;
    @(negedge clk);
    send(8'd9, 1'b1);
    chk("early_valid", 32'(di.out_valid), 1);
    chk("early_sum", 32'(di.out_sum), 9);
    chk("early_cnt", 32'(di.out_cnt), 1);
    ready_mode = 1;
    drain();
    // clear drops partial sum and the product presented with it
    send(8'd50, 1'b0);
    send(8'd60, 1'b0);
    di.clear = 1'b1;
    di.in_valid = 1'b1;
    di.in_prod = 8'd100;
    chk("clear_in_ready", 32'(di.in_ready), 1);
    @(negedge clk);
    di.clear = 1'b0;
    di.in_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) send(8'd1, 1'b0);
    drain();
    // overflow on the 9-bit instance
    wi.in_valid = 1'b1;
    wi.in_prod = 8'd225;
    repeat (4) @(negedge clk);
    wi.in_valid = 1'b0;
    chk("ovf_valid", 32'(wi.out_valid), 1);
`ifdef ACC_SATURATE_EN
    chk("ovf_sum", 32'(wi.out_sum), 511);
`else
    chk("ovf_sum", 32'(wi.out_sum), 388);
`endif
    chk("ovf_flag", 32'(wi.out_ovf), 1);
    chk("ovf_cnt", 32'(wi.out_cnt), 4);
    // random bursts with random gaps and backpressure
    ready_mode = 2;
    for (int b = 0; b < 1000; b++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        send(8'($urandom_range(0, 255)), (k == len - 1) && (len < 4 || $urandom_range(0, 1) == 1));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    ready_mode = 1;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
